// File: rtl/dispensador_billetes_if.sv
// Bus between the card controller / bill mechanism (master side) and the
// dispenser sequencer (slave side).
interface dispensador_billetes_if;
  logic        entregar_dinero;
  logic [31:0] monto;
  logic        recarga_stb;
  logic [1:0]  recarga_sel;
  logic [7:0]  recarga_cant;
  logic        billete_ack;
  logic        billete_req;
  logic [1:0]  billete_sel;
  logic        ocupado;
  logic        entrega_completa;
  logic        error_monto;
  logic        error_mecanico;

  modport master (
    output entregar_dinero, monto, recarga_stb, recarga_sel, recarga_cant, billete_ack,
    input  billete_req, billete_sel, ocupado, entrega_completa, error_monto, error_mecanico
  );

  modport slave (
    input  entregar_dinero, monto, recarga_stb, recarga_sel, recarga_cant, billete_ack,
    output billete_req, billete_sel, ocupado, entrega_completa, error_monto, error_mecanico
  );
endinterface

// File: rtl/dispensador_billetes.sv
// Cash-dispenser sequencer: greedy split of an amount over four cassettes,
// then one-bill-at-a-time req/ack handshake with the bill mechanism.
module dispensador_billetes #(
  parameter logic [31:0] DEN0     = 32'd20000,
  parameter logic [31:0] DEN1     = 32'd10000,
  parameter logic [31:0] DEN2     = 32'd5000,
  parameter logic [31:0] DEN3     = 32'd1000,
  parameter logic [7:0]  CAS_INIT = 8'd10,
  parameter int          TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dispensador_billetes_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, PLAN, DISPENSE, GAP, DONE, ERROR} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   rem_reg;
  logic [1:0]    i_reg;
  logic [7:0]    inv_reg  [4];
  logic [7:0]    tmp_reg  [4];
  logic [7:0]    plan_reg [4];
  logic [TW-1:0] tmo_reg;
  logic          error_monto_reg, error_monto_next;

  logic [3:0]    plan_nz;
  logic [31:0]   den_i;
  logic          can_step, plan_end, req, tmo_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cas
      assign plan_nz[gi] = (plan_reg[gi] != 8'd0);
    end
  endgenerate

  always_comb begin
    den_i = DEN3;
    case (i_reg)
      2'd0: den_i = DEN0;
      2'd1: den_i = DEN1;
      2'd2: den_i = DEN2;
      default: den_i = DEN3;
    endcase
  end

  assign can_step = (rem_reg >= den_i) && (tmp_reg[i_reg] != 8'd0);
  assign plan_end = (i_reg == 2'd3) && !can_step;
  assign req      = (state_reg == DISPENSE) && plan_nz[i_reg];
  assign tmo_hit  = req && !bus.billete_ack && (tmo_reg == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next       = state_reg;
    error_monto_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.entregar_dinero) begin
          if (bus.monto != 32'd0) state_next = PLAN;
          else                    error_monto_next = 1'b1;
        end
      end
      PLAN: begin
        if (plan_end) begin
          if (rem_reg == 32'd0) begin
            state_next = DISPENSE;
          end else begin
            state_next       = IDLE;
            error_monto_next = 1'b1;
          end
        end
      end
      DISPENSE: begin
        if (req && bus.billete_ack) state_next = GAP;
        else if (tmo_hit)           state_next = ERROR;
      end
      GAP:     state_next = (plan_nz != 4'd0) ? DISPENSE : DONE;
      DONE:    state_next = IDLE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: remainder, plan, scratch inventory, live inventory, timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg         <= 32'd0;
      i_reg           <= 2'd0;
      tmo_reg         <= '0;
      error_monto_reg <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        inv_reg[k]  <= CAS_INIT;
        tmp_reg[k]  <= 8'd0;
        plan_reg[k] <= 8'd0;
      end
    end else begin
      error_monto_reg <= error_monto_next;
      case (state_reg)
        IDLE: begin
          if (bus.entregar_dinero) begin
            rem_reg <= bus.monto;
            i_reg   <= 2'd0;
            for (int k = 0; k < 4; k++) begin
              tmp_reg[k]  <= inv_reg[k];
              plan_reg[k] <= 8'd0;
            end
          end else if (bus.recarga_stb) begin
            inv_reg[bus.recarga_sel] <= bus.recarga_cant;
          end
        end
        PLAN: begin
          if (can_step) begin
            rem_reg         <= rem_reg - den_i;
            tmp_reg[i_reg]  <= tmp_reg[i_reg] - 8'd1;
            plan_reg[i_reg] <= plan_reg[i_reg] + 8'd1;
          end else if (i_reg != 2'd3) begin
            i_reg <= i_reg + 2'd1;
          end else begin
            i_reg <= 2'd0;
            // An unpayable plan must not leak into the next withdrawal
            if (rem_reg != 32'd0)
              for (int k = 0; k < 4; k++) plan_reg[k] <= 8'd0;
          end
        end
        DISPENSE: begin
          if (req) begin
            if (bus.billete_ack) begin
              plan_reg[i_reg] <= plan_reg[i_reg] - 8'd1;
              inv_reg[i_reg]  <= inv_reg[i_reg] - 8'd1;
              tmo_reg         <= '0;
            end else if (tmo_hit) begin
              tmo_reg <= '0;
              for (int k = 0; k < 4; k++) plan_reg[k] <= 8'd0;
            end else begin
              tmo_reg <= tmo_reg + TW'(1);
            end
          end else begin
            i_reg <= i_reg + 2'd1;
          end
        end
        DONE: begin
          for (int k = 0; k < 4; k++) plan_reg[k] <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.billete_req      = req;
    bus.billete_sel      = req ? i_reg : 2'd0;
    bus.ocupado          = (state_reg != IDLE);
    bus.entrega_completa = (state_reg == DONE);
    bus.error_monto      = error_monto_reg;
    bus.error_mecanico   = (state_reg == ERROR);
  end

endmodule

// File: tb/tb_dispensador_billetes.sv
// Scoreboard bench for dispensador_billetes: expected events are queued by the
// stimulus, a negedge monitor pops and compares them as the DUT produces them.
module tb_dispensador_billetes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispensador_billetes_if bus ();

  dispensador_billetes dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef enum logic [1:0] {EV_REQ, EV_DONE, EV_ERRM, EV_ERRMEC} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [1:0] sel;
  } ev_t;

  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic ack_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [1:0] s);
    ev_t e;
    e.kind = k;
    e.sel  = s;
    exp_q.push_back(e);
  endtask

  task automatic push_reqs(input logic [1:0] s, input int n);
    for (int k = 0; k < n; k++) push(EV_REQ, s);
  endtask

  // Monitor side of the scoreboard
  task automatic observe(input ev_kind_t k, input logic [1:0] s);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d sel=%0d expected none", k, s);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_REQ && e.sel != s)) begin
        errors++;
        $display("FAIL event: got kind=%0d sel=%0d expected kind=%0d sel=%0d",
                 k, s, e.kind, e.sel);
      end else begin
        $display("event kind=%0d sel=%0d ok at %0t", k, s, $time);
      end
    end
  endtask

  logic       req_prev = 1'b0;
  logic       mec_prev = 1'b0;
  logic [1:0] sel_prev = 2'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.billete_req && !req_prev) observe(EV_REQ, bus.billete_sel);
      if (bus.billete_req && req_prev) chk("sel_stable", bus.billete_sel, sel_prev);
      if (bus.entrega_completa) observe(EV_DONE, 2'd0);
      if (bus.error_monto) observe(EV_ERRM, 2'd0);
      if (bus.error_mecanico && !mec_prev) observe(EV_ERRMEC, 2'd0);
      req_prev = bus.billete_req;
      sel_prev = bus.billete_sel;
      mec_prev = bus.error_mecanico;
    end
  end

  // Bill mechanism model: acks on the second cycle a request is visible
  initial begin
    int hold;
    hold = 0;
    bus.billete_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.billete_req) hold++;
      else hold = 0;
      bus.billete_ack = ack_en && bus.billete_req && (hold >= 2);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start(input logic [31:0] m);
    @(negedge clk);
    bus.entregar_dinero = 1'b1;
    bus.monto           = m;
    @(negedge clk);
    bus.entregar_dinero = 1'b0;
  endtask

  task automatic reload(input logic [1:0] s, input logic [7:0] c);
    @(negedge clk);
    bus.recarga_stb  = 1'b1;
    bus.recarga_sel  = s;
    bus.recarga_cant = c;
    @(negedge clk);
    bus.recarga_stb  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.ocupado) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_idle"}, bus.ocupado, 1'b0);
  endtask

  task automatic wait_req(input logic level, input string name);
    int n;
    n = 0;
    while (bus.billete_req != level && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.billete_req, level);
  endtask

  initial begin
    int n;
    bus.entregar_dinero = 1'b0;
    bus.monto           = 32'd0;
    bus.recarga_stb     = 1'b0;
    bus.recarga_sel     = 2'd0;
    bus.recarga_cant    = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_req", bus.billete_req, 1'b0);
    chk("rst_sel", bus.billete_sel, 2'd0);
    chk("rst_ocupado", bus.ocupado, 1'b0);
    chk("rst_completa", bus.entrega_completa, 1'b0);
    chk("rst_err_monto", bus.error_monto, 1'b0);
    chk("rst_err_mec", bus.error_mecanico, 1'b0);

    // 37000 = 20000 + 10000 + 5000 + 2x1000
    push(EV_REQ, 2'd0); push(EV_REQ, 2'd1); push(EV_REQ, 2'd2);
    push_reqs(2'd3, 2); push(EV_DONE, 2'd0);
    start(32'd37000);
    wait_idle("m37000");

    push(EV_ERRM, 2'd0);
    start(32'd2500);
    wait_idle("m2500");
    push(EV_ERRM, 2'd0);
    start(32'd0);
    wait_idle("m0");

    // Inventory is now 9,9,9,8: empty the big cassettes, then probe cassette 3
    reload(2'd0, 8'd0); reload(2'd1, 8'd0); reload(2'd2, 8'd0);
    push(EV_ERRM, 2'd0);
    start(32'd9000);
    wait_idle("m9000_inv3");
    push_reqs(2'd3, 8); push(EV_DONE, 2'd0);
    start(32'd8000);
    wait_idle("m8000_inv3");

    // Cassette 0 limited to one bill
    do_reset();
    reload(2'd0, 8'd1);
    push(EV_REQ, 2'd0); push_reqs(2'd1, 4); push(EV_DONE, 2'd0);
    start(32'd60000);
    wait_idle("m60000");
    push_reqs(2'd1, 2); push(EV_DONE, 2'd0);
    start(32'd20000);
    wait_idle("m20000_after");

    // Only two 1000 bills available
    do_reset();
    reload(2'd0, 8'd0); reload(2'd1, 8'd0); reload(2'd2, 8'd0); reload(2'd3, 8'd2);
    push(EV_ERRM, 2'd0);
    start(32'd3000);
    wait_idle("m3000_short");
    push_reqs(2'd3, 2); push(EV_DONE, 2'd0);
    start(32'd2000);
    wait_idle("m2000_exact");

    // Withdrawal and reload in the same cycle: reload of cassette 0 is dropped
    do_reset();
    @(negedge clk);
    bus.entregar_dinero = 1'b1;
    bus.monto           = 32'd20000;
    bus.recarga_stb     = 1'b1;
    bus.recarga_sel     = 2'd0;
    bus.recarga_cant    = 8'd0;
    push(EV_REQ, 2'd0); push(EV_DONE, 2'd0);
    @(negedge clk);
    bus.entregar_dinero = 1'b0;
    bus.recarga_stb     = 1'b0;
    wait_idle("m20000_collision");

    // Mechanism timeout
    do_reset();
    ack_en = 1'b0;
    push(EV_REQ, 2'd2); push(EV_ERRMEC, 2'd0);
    start(32'd5000);
    wait_req(1'b1, "tmo_req_rise");
    n = 0;
    while (bus.billete_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", n, 16);
    chk("tmo_err_mec", bus.error_mecanico, 1'b1);
    chk("tmo_req_low", bus.billete_req, 1'b0);
    start(32'd1000);
    reload(2'd0, 8'd5);
    repeat (5) @(negedge clk);
    chk("err_absorbing", bus.error_mecanico, 1'b1);
    chk("err_ocupado", bus.ocupado, 1'b1);
    chk("err_no_req", bus.billete_req, 1'b0);
    do_reset();
    chk("err_cleared", bus.error_mecanico, 1'b0);
    chk("err_idle", bus.ocupado, 1'b0);
    chk("tmo_drained", exp_q.size(), 0);
    ack_en = 1'b1;

    // Busy strobe ignored, then reset between two acks
    push(EV_REQ, 2'd0); push(EV_REQ, 2'd1);
    start(32'd37000);
    wait_req(1'b1, "abort_req0");
    start(32'd1000);
    wait_req(1'b0, "abort_gap");
    wait_req(1'b1, "abort_req1");
    rst = 1'b1;
    @(negedge clk);
    chk("abort_req_low", bus.billete_req, 1'b0);
    chk("abort_idle", bus.ocupado, 1'b0);
    rst = 1'b0;
    // Full cassette 0 restored: 200000 must come entirely from cassette 0
    push_reqs(2'd0, 10); push(EV_DONE, 2'd0);
    start(32'd200000);
    wait_idle("abort_inv_restored");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
